// File: rtl/ks_string_delay_if.sv
// Karplus-Strong delay line sample bus.
// Control, data and status between string loop and delay.
interface ks_string_delay_if #(
  parameter int W  = 8,
  parameter int AW = 8
);
  logic          ce;
  logic          pluck;
  logic          mute;
  logic [AW:0]   len;
  logic [W-1:0]  noise_in;
  logic [W-1:0]  fb_in;
  logic [W-1:0]  out;
  logic          out_valid;
  logic          busy;

  modport master (
    output ce, pluck, mute, len, noise_in, fb_in,
    input  out, out_valid, busy
  );

  modport slave (
    input  ce, pluck, mute, len, noise_in, fb_in,
    output out, out_valid, busy
  );
endinterface

// File: rtl/ks_string_delay.sv
// Programmable circular-buffer delay for the Karplus-Strong loop.
// KS_DELAY_AVG_EN folds a two-tap average into the output path.
module ks_string_delay #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  ks_string_delay_if.slave bus
);
  localparam int MAX_LEN = 2 ** AW;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);
  localparam logic [AW:0] LEN_MIN = (AW+1)'(2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]    state;
  logic [AW:0]   len_q;
  logic [AW:0]   len_c;
  logic [AW:0]   last;
  logic [AW-1:0] wp;
  logic [AW-1:0] wp_nxt;
  logic [W-1:0]  mem [MAX_LEN];
  logic [W-1:0]  rd;
  logic [W-1:0]  wdata;
  logic [W-1:0]  out_d;
  logic          step;
  logic          wr_en;
  logic          wrap;

  // clamp requested length into [2, MAX_LEN]
  always_comb begin
    len_c = bus.len;
    if (bus.len < LEN_MIN)
      len_c = LEN_MIN;
    else if (bus.len > LEN_MAX)
      len_c = LEN_MAX;
  end

  assign step   = bus.ce & ~bus.mute & ~bus.pluck;
  assign last   = len_q - (AW+1)'(1);
  assign wrap   = ({1'b0, wp} == last);
  assign wp_nxt = wrap ? '0 : wp + AW'(1);
  assign rd     = mem[wp];
  assign wr_en  = step & ((state == FILL) | (state == RUN));
  assign wdata  = (state == FILL) ? bus.noise_in : bus.fb_in;
  assign bus.busy = (state == FILL);

`ifdef KS_DELAY_AVG_EN
  logic [W-1:0] prev;
  logic [W:0]   sum;

  assign sum   = {1'b0, rd} + {1'b0, prev};
  assign out_d = sum[W:1];

  // last sample read in RUN, cleared on any restart
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prev <= '0;
    else if (bus.mute | bus.pluck)
      prev <= '0;
    else if (step && state == RUN)
      prev <= rd;
  end
`else
  assign out_d = rd;
`endif

  // sample storage, read-before-write on the same address
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wp] <= wdata;
  end

  // control: mute beats pluck beats strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wp            <= '0;
      len_q         <= LEN_MAX;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.mute) begin
        state   <= IDLE;
        wp      <= '0;
        bus.out <= '0;
      end else if (bus.pluck) begin
        state <= FILL;
        wp    <= '0;
        len_q <= len_c;
      end else if (bus.ce) begin
        unique case (state)
          FILL: begin
            wp <= wp_nxt;
            if (wrap)
              state <= RUN;
          end
          RUN: begin
            wp            <= wp_nxt;
            bus.out       <= out_d;
            bus.out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ks_string_delay.sv
// Directed bench for ks_string_delay.
// Expected values hand-derived; average mode follows KS_DELAY_AVG_EN.
module tb_ks_string_delay;
  localparam int W  = 8;
  localparam int AW = 8;
`ifdef KS_DELAY_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  ks_string_delay_if #(.W(W), .AW(AW)) bus ();

  ks_string_delay #(.W(W), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] ev(input logic [7:0] cur,
                                    input logic [7:0] prv);
    logic [8:0] s;
    s = {1'b0, cur} + {1'b0, prv};
    return AVG ? s[8:1] : cur;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.ce = 1'b1;
    bus.noise_in = d;
    bus.fb_in = d;
    tick();
    bus.ce = 1'b0;
  endtask

  task automatic pluck(input logic [8:0] l);
    bus.len = l;
    bus.pluck = 1'b1;
    tick();
    bus.pluck = 1'b0;
  endtask

  logic [7:0] nz [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  logic [7:0] prv;
  logic [7:0] e;

  initial begin
    bus.ce = 0;
    bus.pluck = 0;
    bus.mute = 0;
    bus.len = 9'd4;
    bus.noise_in = 0;
    bus.fb_in = 0;
    #2;
    check("rst_out", bus.out, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // ce ignored in IDLE
    strobe(8'd99);
    check("idle_valid", bus.out_valid, 0);

    // basic delay, len=4
    pluck(9'd4);
    for (int i = 0; i < 4; i++) begin
      check("fill_busy", bus.busy, 1);
      strobe(nz[i]);
      check("fill_valid", bus.out_valid, 0);
    end
    check("fill_done", bus.busy, 0);
    prv = 0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] raw;
      raw = (i < 4) ? nz[i] : 8'd1;
      e = ev(raw, prv);
      prv = raw;
      strobe(8'(i + 1));
      check("run_valid", bus.out_valid, 1);
      check("run_out", bus.out, e);
    end
    tick();
    check("run_gap_valid", bus.out_valid, 0);
    check("run_hold", bus.out, e);

    // clamp low: len=1 behaves as 2
    pluck(9'd1);
    strobe(8'd7);
    strobe(8'd9);
    check("clamp_lo_busy", bus.busy, 0);
    strobe(8'd0);
    check("clamp_lo_0", bus.out, ev(8'd7, 8'd0));
    strobe(8'd0);
    check("clamp_lo_1", bus.out, ev(8'd9, 8'd7));

    // clamp high: len=300 fills 256
    pluck(9'd300);
    for (int i = 0; i < 256; i++) begin
      if (i == 255)
        check("clamp_hi_busy", bus.busy, 1);
      strobe(8'(i + 3));
    end
    check("clamp_hi_done", bus.busy, 0);
    strobe(8'd0);
    check("clamp_hi_out", bus.out, ev(8'd3, 8'd0));
    e = ev(8'd4, 8'd3);
    strobe(8'd0);
    check("clamp_hi_out1", bus.out, e);

    // re-pluck with simultaneous ce
    bus.len = 9'd3;
    bus.pluck = 1'b1;
    bus.ce = 1'b1;
    bus.fb_in = 8'hAA;
    tick();
    bus.pluck = 1'b0;
    bus.ce = 1'b0;
    check("repl_valid", bus.out_valid, 0);
    check("repl_busy", bus.busy, 1);
    check("repl_hold", bus.out, e);
    strobe(8'd50);
    strobe(8'd60);
    strobe(8'd70);
    check("repl_done", bus.busy, 0);
    strobe(8'd0);
    check("repl_0", bus.out, ev(8'd50, 8'd0));
    strobe(8'd0);
    check("repl_1", bus.out, ev(8'd60, 8'd50));
    strobe(8'd0);
    check("repl_2", bus.out, ev(8'd70, 8'd60));

    // mute during RUN
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;
    check("mute_out", bus.out, 0);
    check("mute_valid", bus.out_valid, 0);
    check("mute_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      strobe(8'd5);
      check("mute_idle", bus.out_valid, 0);
    end

    // sparse strobes, len=2
    pluck(9'd2);
    strobe(8'd11);
    repeat (4) tick();
    strobe(8'd22);
    repeat (4) tick();
    prv = 0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] raw;
      raw = (i == 0) ? 8'd11 : (i == 1) ? 8'd22 : 8'd33;
      e = ev(raw, prv);
      prv = raw;
      strobe(8'(33 + 11 * i));
      check("sparse_valid", bus.out_valid, 1);
      check("sparse_out", bus.out, e);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("sparse_gap", bus.out_valid, 0);
        check("sparse_hold", bus.out, e);
      end
    end

    // async reset mid-FILL
    pluck(9'd4);
    strobe(8'd1);
    strobe(8'd2);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out", bus.out, 0);
    check("arst_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    strobe(8'd3);
    check("arst_idle", bus.out_valid, 0);
    check("arst_idle_busy", bus.busy, 0);
    pluck(9'd2);
    strobe(8'd1);
    strobe(8'd2);
    strobe(8'd0);
    check("arst_new_0", bus.out, ev(8'd1, 8'd0));
    strobe(8'd0);
    check("arst_new_1", bus.out, ev(8'd2, 8'd1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
